// File: rtl/ucode_sequencer.sv
// Microcode sequencer: walks a ROM address range, presents each decoded word to the
// datapath under a valid/ready handshake, then strobes the register-file write.
module ucode_sequencer #(
  parameter int ADDR_W  = 6,
  parameter int CNT_W   = 7,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] end_addr_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [33:0]       rom_data_i,
  output logic              exec_valid_o,
  input  logic              exec_ready_i,
  output logic [3:0]        ra_o,
  output logic [3:0]        rb_o,
  output logic [3:0]        rd_o,
  output logic [2:0]        alu_op_o,
  output logic              imm_sel_o,
  output logic [7:0]        imm_o,
  output logic              ctl_o,
  output logic [7:0]        aux_o,
  output logic              rf_we_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [CNT_W-1:0]  instr_count_o
);

  // The wait counter only has to reach TIMEOUT-1; the timeout fires on the next unready edge.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] endAddr_q;
  logic [33:0]       ir_q;
  logic [CNT_W-1:0]  instrCount_q;
  logic [WAIT_W-1:0] waitCnt_q;

  logic [ADDR_W-1:0] pcInc_d;
  logic [CNT_W-1:0]  instrCount_d;
  logic              timeoutHit_d;

  assign pcInc_d      = pc_q + 1'b1;
  assign instrCount_d = (&instrCount_q) ? instrCount_q : instrCount_q + 1'b1;
  assign timeoutHit_d = (TIMEOUT != 0) && (waitCnt_q == WAIT_W'(TIMEOUT - 1));

  // Abort sits above the state case, so it also wins over start while idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      endAddr_q    <= '0;
      ir_q         <= '0;
      instrCount_q <= '0;
      waitCnt_q    <= '0;
    end else if (abort_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            pc_q         <= start_addr_i;
            endAddr_q    <= end_addr_i;
            instrCount_q <= '0;
            state_q      <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir_q      <= rom_data_i;
          waitCnt_q <= '0;
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_ready_i) begin
            state_q <= S_WB;
          end else if (timeoutHit_d) begin
            state_q <= S_ERR;
          end else if (TIMEOUT != 0) begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
        end
        S_WB: begin
          instrCount_q <= instrCount_d;
          if (pc_q == endAddr_q) begin
            state_q <= S_DONE;
          end else begin
            pc_q    <= pcInc_d;
            state_q <= S_FETCH;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr_o    = pc_q;
  assign exec_valid_o  = (state_q == S_EXEC);
  assign rf_we_o       = (state_q == S_WB) && ir_q[13];
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign error_o       = (state_q == S_ERR);
  assign instr_count_o = instrCount_q;

  assign aux_o     = ir_q[33:26];
  assign ra_o      = ir_q[25:22];
  assign rb_o      = ir_q[21:18];
  assign rd_o      = ir_q[17:14];
  assign imm_sel_o = ir_q[12];
  assign ctl_o     = ir_q[11];
  assign alu_op_o  = ir_q[10:8];
  assign imm_o     = ir_q[7:0];

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer: a ROM array plus a transaction-level model
// of the expected address walk, handshake timing and retired-instruction count.
module tb_ucode_sequencer;

  localparam int ADDR_W  = 6;
  localparam int CNT_W   = 7;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rstN;
  logic              startI;
  logic [ADDR_W-1:0] startAddr;
  logic [ADDR_W-1:0] endAddr;
  logic              abortI;
  logic [ADDR_W-1:0] romAddr;
  logic [33:0]       romData;
  logic              execValid;
  logic              execReady;
  logic [3:0]        ra, rb, rd;
  logic [2:0]        aluOp;
  logic              immSel;
  logic [7:0]        imm;
  logic              ctl;
  logic [7:0]        aux;
  logic              rfWe;
  logic              busy;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  instrCount;

  logic [33:0] rom [64];

  int checks = 0;
  int errors = 0;

  ucode_sequencer #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .start_i      (startI),
    .start_addr_i (startAddr),
    .end_addr_i   (endAddr),
    .abort_i      (abortI),
    .rom_addr_o   (romAddr),
    .rom_data_i   (romData),
    .exec_valid_o (execValid),
    .exec_ready_i (execReady),
    .ra_o         (ra),
    .rb_o         (rb),
    .rd_o         (rd),
    .alu_op_o     (aluOp),
    .imm_sel_o    (immSel),
    .imm_o        (imm),
    .ctl_o        (ctl),
    .aux_o        (aux),
    .rf_we_o      (rfWe),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .instr_count_o(instrCount)
  );

  always #5 clk = ~clk;

  assign romData = rom[romAddr];

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [33:0] mkWord(input logic [7:0] a, input logic [3:0] sa, input logic [3:0] sb,
                                         input logic [3:0] sd, input logic wen, input logic isel,
                                         input logic c, input logic [2:0] op, input logic [7:0] im);
    return {a, sa, sb, sd, wen, isel, c, op, im};
  endfunction

  // Field view of a ROM word in the order of the observed bundle below.
  function automatic logic [63:0] expFields(input logic [33:0] w);
    return 64'({w[33:26], w[25:22], w[21:18], w[17:14], w[12], w[11], w[10:8], w[7:0]});
  endfunction

  function automatic logic [63:0] obsFields();
    return 64'({aux, ra, rb, rd, immSel, ctl, aluOp, imm});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One program run; optionally aborts instruction abortIdx in EXEC or in WB.
  task automatic applyStimulus(input int sa, input int ea, input int fixedWait,
                               input int abortIdx, input bit abortInWb);
    int n;
    int addr;
    int waits;
    int expCount;
    logic [33:0] w;
    n = ((ea - sa + 64) % 64) + 1;
    expCount = 0;
    startI    = 1'b1;
    startAddr = 6'(sa);
    endAddr   = 6'(ea);
    tick();
    startI = 1'b0;
    for (int k = 0; k < n; k++) begin
      addr = (sa + k) % 64;
      w = rom[addr];
      checkOutput("fetchAddr", 64'(romAddr), 64'(addr));
      checkOutput("fetchBusy", 64'(busy), 64'd1);
      checkOutput("fetchValid", 64'(execValid), 64'd0);
      checkOutput("fetchDoneErr", 64'({done, error, rfWe}), 64'd0);
      tick();
      waits = (fixedWait >= 0) ? fixedWait : int'($urandom_range(0, 4));
      for (int c = 0; c <= waits; c++) begin
        if (k == abortIdx && !abortInWb && c == waits) begin
          abortI    = 1'b1;
          execReady = 1'b0;
          startI    = 1'b0;
          checkOutput("abortExecValid", 64'(execValid), 64'd1);
          tick();
          abortI = 1'b0;
          checkOutput("abortExecIdle", 64'({busy, execValid, rfWe, done, error}), 64'd0);
          checkOutput("abortExecCount", 64'(instrCount), 64'(expCount));
          checkOutput("abortExecPc", 64'(romAddr), 64'(addr));
          tick();
          checkOutput("abortExecNoDone", 64'({busy, done, rfWe}), 64'd0);
          return;
        end
        execReady = (c == waits);
        startI    = 1'($urandom_range(0, 1));
        startAddr = 6'($urandom_range(0, 63));
        endAddr   = 6'($urandom_range(0, 63));
        checkOutput("execValid", 64'(execValid), 64'd1);
        checkOutput("execFields", obsFields(), expFields(w));
        checkOutput("execNoWe", 64'({rfWe, done, error}), 64'd0);
        tick();
      end
      execReady = 1'b0;
      startI    = 1'b0;
      checkOutput("wbWe", 64'(rfWe), 64'(w[13]));
      checkOutput("wbRd", 64'(rd), 64'(w[17:14]));
      checkOutput("wbValid", 64'(execValid), 64'd0);
      if (k == abortIdx && abortInWb) begin
        abortI = 1'b1;
        tick();
        abortI = 1'b0;
        checkOutput("abortWbIdle", 64'({busy, rfWe, done}), 64'd0);
        checkOutput("abortWbCount", 64'(instrCount), 64'(expCount));
        checkOutput("abortWbPc", 64'(romAddr), 64'(addr));
        return;
      end
      expCount++;
      tick();
    end
    checkOutput("doneHigh", 64'({done, error, busy}), 64'b101);
    checkOutput("doneCount", 64'(instrCount), 64'(n));
    tick();
    checkOutput("doneLow", 64'({done, busy, error}), 64'd0);
    checkOutput("idleCount", 64'(instrCount), 64'(n));
    checkOutput("idlePc", 64'(romAddr), 64'(ea));
  endtask

  task automatic runTimeout(input int sa);
    startI    = 1'b1;
    startAddr = 6'(sa);
    endAddr   = 6'(sa);
    execReady = 1'b0;
    tick();
    startI = 1'b0;
    checkOutput("toFetchAddr", 64'(romAddr), 64'(sa));
    tick();
    for (int c = 0; c < TIMEOUT; c++) begin
      checkOutput("toExecValid", 64'({execValid, error}), 64'b10);
      tick();
    end
    checkOutput("toError", 64'({error, done, rfWe, execValid}), 64'b1000);
    tick();
    checkOutput("toIdle", 64'({busy, error, done}), 64'd0);
    checkOutput("toCount", 64'(instrCount), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sa;
    for (int i = 0; i < 64; i++) rom[i] = {2'($urandom_range(0, 3)), 32'($urandom)};
    rom[0] = mkWord(8'h11, 4'h1, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 3'b000, 8'h7C);
    rom[1] = mkWord(8'h22, 4'h3, 4'h4, 4'h1, 1'b1, 1'b1, 1'b0, 3'b001, 8'h1C);
    rom[2] = mkWord(8'h33, 4'h5, 4'h6, 4'h2, 1'b1, 1'b0, 1'b1, 3'b010, 8'hC7);
    rom[3] = mkWord(8'hA5, 4'h0, 4'h1, 4'h5, 1'b1, 1'b1, 1'b1, 3'b100, 8'h33);

    rstN = 1'b0; startI = 1'b0; startAddr = '0; endAddr = '0; abortI = 1'b0; execReady = 1'b0;
    repeat (3) tick();
    rstN = 1'b1;
    checkOutput("resetState", 64'({busy, execValid, rfWe, done, error}), 64'd0);
    checkOutput("resetAddrCount", 64'({romAddr, instrCount}), 64'd0);

    applyStimulus(0, 2, 0, -1, 1'b0);
    applyStimulus(3, 3, 5, -1, 1'b0);
    applyStimulus(62, 1, 0, -1, 1'b0);
    runTimeout(7);
    applyStimulus(0, 5, -1, 1, 1'b0);
    applyStimulus(4, 8, -1, 2, 1'b1);

    startI = 1'b1; abortI = 1'b1; startAddr = 6'd9; endAddr = 6'd9;
    tick();
    startI = 1'b0; abortI = 1'b0;
    checkOutput("abortStartIdle", 64'(busy), 64'd0);

    startI = 1'b1; startAddr = 6'd10; endAddr = 6'd20; execReady = 1'b0;
    tick();
    startI = 1'b0;
    tick();
    checkOutput("preResetExec", 64'(execValid), 64'd1);
    rstN = 1'b0;
    tick();
    checkOutput("midReset", 64'({busy, execValid, rfWe, done, error}), 64'd0);
    checkOutput("midResetAddr", 64'({romAddr, instrCount}), 64'd0);
    tick();
    rstN = 1'b1;
    tick();
    checkOutput("postReset", 64'({busy, execValid, rfWe, romAddr, instrCount}), 64'd0);

    for (int r = 0; r < 15; r++) begin
      sa = int'($urandom_range(0, 63));
      applyStimulus(sa, (sa + int'($urandom_range(0, 20))) % 64, -1, -1, 1'b0);
    end
    applyStimulus(5, 4, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
